// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and sizing for the memory responder.
package mem_responder_pkg;
  localparam int XLEN = 32;
  localparam int NUM_MEM_TAGS = 15;
  localparam int MEM_LATENCY_IN_CYCLES = 20;
  localparam int TAG_W = $clog2(NUM_MEM_TAGS + 1);
  localparam int BLK_W = XLEN - 3;
  localparam int CNT_W = $clog2(MEM_LATENCY_IN_CYCLES);
  typedef logic [TAG_W-1:0] MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [XLEN-1:0] ADDR;
  typedef logic [BLK_W-1:0] BLK_IDX;
  typedef struct packed {
    logic valid;
    ADDR  addr;
  } I_ADDR_PACKET;
  typedef struct packed {
    logic             valid;
    MEM_TAG           tag;
    BLK_IDX           blk;
    logic [CNT_W-1:0] cnt;
  } MEM_REQ_ENTRY;
  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(NUM_MEM_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/mem_responder_tag_pool.sv
// mem_tag_pool: free-tag bitmask with lowest-free allocation and one release per cycle.
module mem_tag_pool
  import mem_responder_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   alloc_i,
  input  MEM_TAG rel_tag_i,
  output logic   any_free_o,
  output MEM_TAG alloc_tag_o
);
  logic [NUM_MEM_TAGS:1] free_q, free_d;
  always_comb begin
    alloc_tag_o = '0;
    for (int i = NUM_MEM_TAGS; i >= 1; i--) alloc_tag_o = free_q[i] ? MEM_TAG'(i) : alloc_tag_o;
  end
  assign any_free_o = |free_q;
  always_comb begin
    free_d = free_q;
    if (alloc_i) free_d[alloc_tag_o] = 1'b0;
    if (rel_tag_i != '0) free_d[rel_tag_i] = 1'b1;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) free_q <= '1;
    else free_q <= free_d;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrates cache reads, tags them, and returns SRAM blocks after a fixed latency.
module mem_responder
  import mem_responder_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  I_ADDR_PACKET     icache_req_addr,
  input  logic             dcache_req_valid,
  input  ADDR              dcache_req_addr,
  output logic             icache_req_accepted,
  output logic             dcache_req_accepted,
  output MEM_TAG           current_req_tag,
  output MEM_BLOCK         mem_data,
  output MEM_TAG           mem_data_tag,
  output logic             sram_rd_en,
  output logic [XLEN-4:0]  sram_rd_addr,
  input  MEM_BLOCK         sram_rd_data
);
  MEM_REQ_ENTRY fifo_q [NUM_MEM_TAGS];
  MEM_REQ_ENTRY fifo_d [NUM_MEM_TAGS];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  MEM_TAG ret_tag_q, alloc_tag;
  logic any_free, accept, issue;
  BLK_IDX req_blk;
  logic unused_addr_bits;
  mem_tag_pool u_pool (
    .clock       (clock),
    .reset       (reset),
    .alloc_i     (accept),
    .rel_tag_i   (ret_tag_q),
    .any_free_o  (any_free),
    .alloc_tag_o (alloc_tag)
  );
  assign dcache_req_accepted = !reset && any_free && dcache_req_valid;
  assign icache_req_accepted = !reset && any_free && icache_req_addr.valid && !dcache_req_valid;
  assign accept = dcache_req_accepted || icache_req_accepted;
  assign current_req_tag = accept ? alloc_tag : '0;
  assign req_blk = dcache_req_valid ? dcache_req_addr[XLEN-1:3] : icache_req_addr.addr[XLEN-1:3];
  assign unused_addr_bits = ^{dcache_req_addr[2:0], icache_req_addr.addr[2:0]};
  // Entries age in lockstep, so only the head can ever reach zero first.
  assign issue = fifo_q[head_q].valid && fifo_q[head_q].cnt == '0;
  assign sram_rd_en = issue;
  assign sram_rd_addr = fifo_q[head_q].blk;
  assign mem_data_tag = ret_tag_q;
  assign mem_data = (ret_tag_q != '0) ? sram_rd_data : '0;
  always_comb begin
    fifo_d = fifo_q;
    for (int i = 0; i < NUM_MEM_TAGS; i++)
      fifo_d[i].cnt = (fifo_q[i].valid && fifo_q[i].cnt != '0) ? fifo_q[i].cnt - 1'b1 : fifo_q[i].cnt;
    if (issue) fifo_d[head_q].valid = 1'b0;
    if (accept) fifo_d[tail_q] = '{valid: 1'b1, tag: alloc_tag, blk: req_blk, cnt: CNT_W'(MEM_LATENCY_IN_CYCLES - 2)};
    head_d = issue ? ptr_inc(head_q) : head_q;
    tail_d = accept ? ptr_inc(tail_q) : tail_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_MEM_TAGS; i++) fifo_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      ret_tag_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ret_tag_q <= issue ? fifo_q[head_q].tag : '0;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the cache request protocol. It arbitrates read requests from the icache subsystem and the dcache, allocates a memory tag per accepted request, and fronts a synchronous block SRAM. Each request is returned as mem_data/mem_data_tag exactly MEM_LATENCY cycles after acceptance. It sits between the cache subsystems' request ports and the backing memory.

Parameters:
NUM_TAGS, `NUM_MEM_TAGS, number of usable tags; legal tags are 1..NUM_TAGS and tag 0 means "no tag".
MEM_LATENCY, `MEM_LATENCY_IN_CYCLES, cycles from accept to data return; must be >= 2.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
icache_req_addr  in  I_ADDR_PACKET  icache read request (valid + addr)
dcache_req_valid  in  1  dcache read request valid
dcache_req_addr  in  ADDR  dcache read address
icache_req_accepted  out  1  icache request taken this cycle
dcache_req_accepted  out  1  dcache request taken this cycle
current_req_tag  out  MEM_TAG  tag assigned this cycle; 0 if nothing accepted
mem_data  out  MEM_BLOCK  returned block; '0 when mem_data_tag == 0
mem_data_tag  out  MEM_TAG  tag of returning block; 0 = no return
sram_rd_en  out  1  SRAM block read strobe
sram_rd_addr  out  [`XLEN-4:0]  block index = addr[31:3]
sram_rd_data  in  MEM_BLOCK  SRAM data, valid the cycle after sram_rd_en

Behaviour:
- Reset (async, active-high): free mask = all free; in-flight FIFO emptied; return register cleared. All outputs are 0 while reset is high. In-flight requests are dropped and never returned.
- Arbitration, combinational, at most one accept per cycle:
  - dcache has fixed priority over icache.
  - Accept only if at least one tag is free.
  - The loser's accepted signal is 0. The requester holds its request and retries.
- Tag allocation:
  - The lowest-numbered free tag is assigned and driven on current_req_tag in the same cycle the accepted signal is high.
  - The tag is marked busy at the clock edge.
  - Tag 0 is never issued.
- In-flight FIFO:
  - Depth NUM_TAGS; cannot overflow because it is bounded by the tag count.
  - Entry = {tag, block index, countdown}. On accept, push with countdown = MEM_LATENCY-2.
  - Every cycle, all valid countdowns decrement, saturating at 0.
- Issue:
  - When the head is valid with countdown == 0: assert sram_rd_en with the head block index and pop the head.
  - Fixed latency plus at most one accept per cycle guarantees at most one ready head per cycle, in order.
- Return:
  - Cycle after issue: mem_data = sram_rd_data and mem_data_tag = head tag (registered tag, data passed through).
  - For an accept in cycle T: SRAM read in T+MEM_LATENCY-1, return in T+MEM_LATENCY.
  - Responses come back in acceptance order, one per cycle at most.
- Tag release:
  - A tag is freed at the end of its return cycle and is allocatable from the next cycle.
  - No same-cycle reuse, so a tag is never both returning and newly assigned in one cycle.
- Addresses: low 3 bits are ignored; a request to 0x104 reads block index 0x20.
- Full (all NUM_TAGS busy): both accepted signals = 0 and current_req_tag = 0. A release in cycle C makes an accept possible in C+1.
- Simultaneous accept and return in one cycle are independent. Simultaneous push and pop of the FIFO are legal, including when it holds exactly one entry.

Decomposition:
- sys_defs.svh holds MEM_TAG, MEM_BLOCK, ADDR, I_ADDR_PACKET, `NUM_MEM_TAGS and `MEM_LATENCY_IN_CYCLES.
- Add MEM_REQ_ENTRY {valid, tag, block index, countdown} to sys_defs.svh.
- Sub-module mem_tag_pool:
  - Holds the free bitmask, lowest-free priority encoder, allocate strobe and release port.
  - Outputs: any_free and alloc_tag.

Test Plan:
1. Single icache req to addr 0x100 in cycle 5 -> icache_req_accepted=1 and current_req_tag=1 in cycle 5; sram_rd_en with addr 0x20 in 5+L-1; mem_data_tag=1 with SRAM data in 5+L.
2. icache and dcache both valid in cycle 0 -> dcache gets tag 1, icache not accepted; icache gets tag 2 in cycle 1; returns with tags 1 and 2 in consecutive cycles L and L+1.
3. Issue 15 back-to-back accepts (NUM_TAGS=15) -> 16th request rejected with current_req_tag=0 until tag 1 returns in cycle L; a request in L+1 is accepted with tag 1.
4. Assert reset asynchronously between edges with 3 in flight -> outputs 0 immediately, no returns after deassert; first post-reset request gets tag 1.
5. Idle for 100 cycles -> current_req_tag=0, mem_data_tag=0, mem_data='0 and sram_rd_en=0 throughout.
6. icache req to 0x104 -> sram_rd_addr=0x20; mem_data_tag is never 0 for a real return.
